// File: rtl/my_pkg.sv
// Shared types for the instruction fetch front end: FSM states, queue entry
// layout and the NOP returned to decode when nothing has been fetched.
package my_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer of {pc, instr} with push, pop
// and a flush that empties it on the same edge (flush beats push).
module fetch_fifo
   import my_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && !pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding IMEM request, prefetch queue to decode,
// branch redirect with response squash. Optional FETCH_PERF_CNT_EN adds the bubble counter.
module fetch_unit
   import my_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         EN,
   input  logic         START,
   output logic         IMEM_req_o,
   output logic [31:0]  IMEM_addr_o,
   input  logic         IMEM_gnt_i,
   input  logic         IMEM_rvalid_i,
   input  logic [31:0]  IMEM_rdata_i,
   input  logic         BR_redirect_i,
   input  logic [31:0]  BR_target_i,
   input  logic         ID_stall_i,
   output logic [31:0]  ID_instr_o,
   output logic [31:0]  ID_pc_o,
   output logic         ID_valid_o,
   output logic [31:0]  PERF_bubble_o,
   output fetch_state_e dbg_state_o
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          push, pop, flush, redirect, id_valid, granted;
   logic [CW-1:0] count;
   fetch_entry_t  head, push_data;

   assign id_valid    = (count != '0);
   assign pop         = id_valid && EN && !ID_stall_i;
   assign redirect    = BR_redirect_i && EN;
   assign IMEM_req_o  = (state_q == REQ) && EN && START;
   assign IMEM_addr_o = fetch_pc_q;
   assign granted     = IMEM_req_o && IMEM_gnt_i;
   assign push_data   = '{pc: req_pc_q, instr: IMEM_rdata_i};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      flush      = 1'b0;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = BR_target_i;
               state_d    = REQ;
            end else if (EN && START && count < DEPTH_C) begin
               state_d = REQ;
            end
         end
         REQ: begin
            // A grant alongside a redirect is still in flight, so its response must be squashed.
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = BR_target_i;
               if (granted) state_d = FLUSH;
            end else if (granted) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = WAIT;
            end else if (EN && !START) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = BR_target_i;
               state_d    = IMEM_rvalid_i ? REQ : FLUSH;
            end else if (IMEM_rvalid_i) begin
               push    = 1'b1;
               state_d = ((count + CW'(1) - CW'(pop)) < DEPTH_C) ? REQ : IDLE;
            end
         end
         FLUSH: begin
            if (redirect) begin
               flush      = 1'b1;
               fetch_pc_d = BR_target_i;
            end
            if (IMEM_rvalid_i) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (CLK),
      .rst_n     (RSTn),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count)
   );

   assign ID_valid_o  = id_valid;
   assign ID_instr_o  = id_valid ? head.instr : NOP_INSTR;
   assign ID_pc_o     = id_valid ? head.pc : 32'h0;
   assign dbg_state_o = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_q, bubble_d;

   always_comb begin
      bubble_d = bubble_q;
      if (EN && START && !id_valid && !ID_stall_i && bubble_q != 32'hFFFF_FFFF)
         bubble_d = bubble_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) bubble_q <= '0;
      else       bubble_q <= bubble_d;
   end

   assign PERF_bubble_o = bubble_q;
`else
   assign PERF_bubble_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against a
// transaction-level model (queue of {pc, instr}, outstanding/squash flags).
module tb_fetch_unit;
   import my_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic         CLK = 1'b0;
   logic         RSTn, EN, START;
   logic         IMEM_gnt_i, IMEM_rvalid_i, BR_redirect_i, ID_stall_i;
   logic [31:0]  IMEM_rdata_i, BR_target_i;
   logic         IMEM_req_o, ID_valid_o;
   logic [31:0]  IMEM_addr_o, ID_instr_o, ID_pc_o, PERF_bubble_o;
   fetch_state_e dbg_state;

   int errors = 0;
   int checks = 0;

   // Reference model
   logic [63:0] m_q[$];
   logic [31:0] m_pc, m_addr, m_bub;
   logic        m_req, m_out, m_drop;
   logic        mem_pend;

   always #5 CLK = ~CLK;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .EN            (EN),
      .START         (START),
      .IMEM_req_o    (IMEM_req_o),
      .IMEM_addr_o   (IMEM_addr_o),
      .IMEM_gnt_i    (IMEM_gnt_i),
      .IMEM_rvalid_i (IMEM_rvalid_i),
      .IMEM_rdata_i  (IMEM_rdata_i),
      .BR_redirect_i (BR_redirect_i),
      .BR_target_i   (BR_target_i),
      .ID_stall_i    (ID_stall_i),
      .ID_instr_o    (ID_instr_o),
      .ID_pc_o       (ID_pc_o),
      .ID_valid_o    (ID_valid_o),
      .PERF_bubble_o (PERF_bubble_o),
      .dbg_state_o   (dbg_state)
   );

   // Advance one clock: update the model from the inputs now applied, end at the next negedge.
   task automatic tick();
      int   sz;
      logic pop, redir, acc;
      if (!RSTn) begin
         m_q.delete();
         m_pc   = RESET_PC;
         m_addr = '0;
         m_bub  = '0;
         m_req  = 1'b0;
         m_out  = 1'b0;
         m_drop = 1'b0;
      end else begin
         sz    = m_q.size();
         pop   = (sz != 0) && EN && !ID_stall_i;
         redir = BR_redirect_i && EN;
`ifdef FETCH_PERF_CNT_EN
         if (EN && START && sz == 0 && !ID_stall_i && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
`endif
         if (m_out) begin
            if (redir) begin
               m_q.delete();
               m_pc = BR_target_i;
               if (IMEM_rvalid_i) begin
                  m_out = 1'b0; m_drop = 1'b0; m_req = 1'b1;
               end else begin
                  m_drop = 1'b1;
               end
            end else begin
               if (pop) void'(m_q.pop_front());
               if (IMEM_rvalid_i) begin
                  m_out = 1'b0;
                  if (m_drop) begin
                     m_drop = 1'b0; m_req = 1'b1;
                  end else begin
                     m_q.push_back({m_addr, IMEM_rdata_i});
                     m_req = (m_q.size() < DEPTH);
                  end
               end
            end
         end else if (m_req) begin
            acc = EN && START && IMEM_gnt_i;
            if (redir) begin
               m_q.delete();
               m_pc = BR_target_i;
               if (acc) begin
                  m_out = 1'b1; m_drop = 1'b1; m_req = 1'b0;
               end
            end else begin
               if (pop) void'(m_q.pop_front());
               if (acc) begin
                  m_out = 1'b1; m_addr = m_pc; m_pc = m_pc + 32'd4; m_req = 1'b0;
               end else if (EN && !START) begin
                  m_req = 1'b0;
               end
            end
         end else begin
            if (redir) begin
               m_q.delete();
               m_pc  = BR_target_i;
               m_req = 1'b1;
            end else begin
               if (pop) void'(m_q.pop_front());
               if (EN && START && sz < DEPTH) m_req = 1'b1;
            end
         end
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic quiet_inputs();
      IMEM_gnt_i    = 1'b0;
      IMEM_rvalid_i = 1'b0;
      IMEM_rdata_i  = '0;
      BR_redirect_i = 1'b0;
      BR_target_i   = '0;
      ID_stall_i    = 1'b0;
   endtask

   task automatic apply_reset();
      RSTn  = 1'b0;
      EN    = 1'b0;
      START = 1'b0;
      quiet_inputs();
      mem_pend = 1'b0;
      tick();
      tick();
      RSTn = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (IMEM_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", IMEM_req_o); end
      checks++; if (IMEM_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", IMEM_addr_o, RESET_PC); end
      checks++; if (ID_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ID_valid_o); end
      checks++; if (ID_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", ID_instr_o); end
      checks++; if (ID_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", ID_pc_o); end
      checks++; if (PERF_bubble_o !== 32'h0) begin errors++; $display("FAIL reset_perf: got %h expected 0", PERF_bubble_o); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
   endtask

   task automatic test_perf();
      logic [31:0] exp_bub;
`ifdef FETCH_PERF_CNT_EN
      exp_bub = 32'd10;
`else
      exp_bub = 32'd0;
`endif
      apply_reset();
      EN = 1'b1; START = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (PERF_bubble_o !== exp_bub) begin errors++; $display("FAIL perf_starve: got %0d expected %0d", PERF_bubble_o, exp_bub); end
      checks++; if (IMEM_req_o !== 1'b1) begin errors++; $display("FAIL perf_req_held: got %b expected 1", IMEM_req_o); end
   endtask

   task automatic test_first_fetch();
      apply_reset();
      EN = 1'b1; START = 1'b1;
      tick();
      checks++; if (IMEM_req_o !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", IMEM_req_o); end
      checks++; if (IMEM_addr_o !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", IMEM_addr_o); end
      IMEM_gnt_i = 1'b1;
      tick();
      IMEM_gnt_i = 1'b0;
      checks++; if (IMEM_req_o !== 1'b0) begin errors++; $display("FAIL first_wait_req: got %b expected 0", IMEM_req_o); end
      checks++; if (IMEM_addr_o !== 32'h4) begin errors++; $display("FAIL first_next_pc: got %h expected 4", IMEM_addr_o); end
      IMEM_rvalid_i = 1'b1; IMEM_rdata_i = 32'h0050_0093;
      checks++; if (ID_valid_o !== 1'b0) begin errors++; $display("FAIL first_no_bypass: got %b expected 0", ID_valid_o); end
      tick();
      IMEM_rvalid_i = 1'b0;
      checks++; if (ID_valid_o !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", ID_valid_o); end
      checks++; if (ID_pc_o !== 32'h0) begin errors++; $display("FAIL first_pc: got %h expected 0", ID_pc_o); end
      checks++; if (ID_instr_o !== 32'h0050_0093) begin errors++; $display("FAIL first_instr: got %h expected 00500093", ID_instr_o); end
   endtask

   task automatic test_stall_fill();
      logic        saw_req;
      logic [31:0] first_addr;
      apply_reset();
      EN = 1'b1; START = 1'b1; ID_stall_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         IMEM_gnt_i    = 1'b1;
         IMEM_rvalid_i = mem_pend;
         IMEM_rdata_i  = 32'h1000_0000 + c;
         #1;
         if (IMEM_rvalid_i) mem_pend = 1'b0;
         if (IMEM_req_o && IMEM_gnt_i) mem_pend = 1'b1;
         tick();
      end
      quiet_inputs();
      ID_stall_i = 1'b1;
      checks++; if (IMEM_req_o !== 1'b0) begin errors++; $display("FAIL fill_req_off: got %b expected 0", IMEM_req_o); end
      checks++; if (IMEM_addr_o !== 32'h10) begin errors++; $display("FAIL fill_next_pc: got %h expected 10", IMEM_addr_o); end
      ID_stall_i = 1'b0;
      saw_req    = 1'b0;
      first_addr = '0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (ID_pc_o !== 32'(4 * i)) begin errors++; $display("FAIL fill_order_%0d: got %h expected %h", i, ID_pc_o, 32'(4 * i)); end
         if (IMEM_req_o && !saw_req) begin saw_req = 1'b1; first_addr = IMEM_addr_o; end
         tick();
      end
      checks++; if (!saw_req || first_addr !== 32'h10) begin errors++; $display("FAIL fill_resume: got req=%b addr=%h expected req=1 addr=10", saw_req, first_addr); end
      checks++; if (ID_valid_o !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b expected 0", ID_valid_o); end
   endtask

   task automatic test_redirect_wait();
      apply_reset();
      EN = 1'b1; START = 1'b1;
      tick();
      IMEM_gnt_i = 1'b1;
      tick();
      IMEM_gnt_i = 1'b0;
      BR_redirect_i = 1'b1; BR_target_i = 32'h0000_0100;
      tick();
      BR_redirect_i = 1'b0;
      checks++; if (IMEM_req_o !== 1'b0 || IMEM_addr_o !== 32'h100) begin errors++; $display("FAIL redir_flush: got req=%b addr=%h expected req=0 addr=100", IMEM_req_o, IMEM_addr_o); end
      IMEM_rvalid_i = 1'b1; IMEM_rdata_i = 32'hDEAD_BEEF;
      tick();
      IMEM_rvalid_i = 1'b0;
      checks++; if (ID_valid_o !== 1'b0) begin errors++; $display("FAIL redir_dropped: got %b expected 0", ID_valid_o); end
      checks++; if (IMEM_req_o !== 1'b1 || IMEM_addr_o !== 32'h100) begin errors++; $display("FAIL redir_req: got req=%b addr=%h expected req=1 addr=100", IMEM_req_o, IMEM_addr_o); end
      IMEM_gnt_i = 1'b1;
      tick();
      IMEM_gnt_i = 1'b0;
      IMEM_rvalid_i = 1'b1; IMEM_rdata_i = 32'h1111_1111;
      tick();
      IMEM_rvalid_i = 1'b0;
      checks++; if (ID_valid_o !== 1'b1 || ID_pc_o !== 32'h100 || ID_instr_o !== 32'h1111_1111) begin
         errors++; $display("FAIL redir_first: got v=%b pc=%h instr=%h expected v=1 pc=100 instr=11111111", ID_valid_o, ID_pc_o, ID_instr_o);
      end
   endtask

   task automatic test_redirect_rvalid();
      apply_reset();
      EN = 1'b1; START = 1'b1;
      tick();
      IMEM_gnt_i = 1'b1;
      tick();
      IMEM_gnt_i = 1'b0;
      BR_redirect_i = 1'b1; BR_target_i = 32'h0000_0200;
      IMEM_rvalid_i = 1'b1; IMEM_rdata_i = 32'hCAFE_0001;
      tick();
      quiet_inputs();
      checks++; if (ID_valid_o !== 1'b0) begin errors++; $display("FAIL redir_rv_valid: got %b expected 0", ID_valid_o); end
      checks++; if (IMEM_req_o !== 1'b1 || IMEM_addr_o !== 32'h200) begin errors++; $display("FAIL redir_rv_req: got req=%b addr=%h expected req=1 addr=200", IMEM_req_o, IMEM_addr_o); end
   endtask

   task automatic test_wrap();
      apply_reset();
      EN = 1'b1; START = 1'b1;
      BR_redirect_i = 1'b1; BR_target_i = 32'hFFFF_FFFC;
      tick();
      BR_redirect_i = 1'b0;
      checks++; if (IMEM_req_o !== 1'b1 || IMEM_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffffc", IMEM_req_o, IMEM_addr_o); end
      IMEM_gnt_i = 1'b1;
      tick();
      IMEM_gnt_i = 1'b0;
      checks++; if (IMEM_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", IMEM_addr_o); end
      IMEM_rvalid_i = 1'b1; IMEM_rdata_i = 32'h0000_0073;
      tick();
      IMEM_rvalid_i = 1'b0;
      checks++; if (ID_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", ID_pc_o); end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      EN = 1'b1; START = 1'b1;
      tick();
      IMEM_gnt_i = 1'b1;
      tick();
      IMEM_gnt_i = 1'b0;
      RSTn = 1'b0;
      tick();
      RSTn = 1'b1;
      IMEM_rvalid_i = 1'b1; IMEM_rdata_i = 32'hBAD0_BAD0;
      tick();
      IMEM_rvalid_i = 1'b0;
      checks++; if (ID_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wait_ignored: got %b expected 0", ID_valid_o); end
      checks++; if (IMEM_req_o !== 1'b1 || IMEM_addr_o !== RESET_PC) begin errors++; $display("FAIL rst_wait_req: got req=%b addr=%h expected req=1 addr=%h", IMEM_req_o, IMEM_addr_o, RESET_PC); end
   endtask

   task automatic test_random();
      logic [63:0] head_e;
      logic [31:0] exp_pc, exp_instr;
      logic        exp_req;
      apply_reset();
      for (int c = 0; c < 1500; c++) begin
         exp_pc    = 32'h0;
         exp_instr = NOP_INSTR;
         if (m_q.size() != 0) begin
            head_e    = m_q[0];
            exp_pc    = head_e[63:32];
            exp_instr = head_e[31:0];
         end
         exp_req = m_req && EN && START;
         checks++; if (ID_valid_o !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, ID_valid_o, (m_q.size() != 0)); end
         checks++; if (ID_pc_o !== exp_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, ID_pc_o, exp_pc); end
         checks++; if (ID_instr_o !== exp_instr) begin errors++; $display("FAIL rnd_instr c%0d: got %h expected %h", c, ID_instr_o, exp_instr); end
         checks++; if (IMEM_req_o !== exp_req) begin errors++; $display("FAIL rnd_req c%0d: got %b expected %b", c, IMEM_req_o, exp_req); end
         checks++; if (IMEM_addr_o !== m_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, IMEM_addr_o, m_pc); end
         checks++; if (PERF_bubble_o !== m_bub) begin errors++; $display("FAIL rnd_perf c%0d: got %0d expected %0d", c, PERF_bubble_o, m_bub); end

         EN            = ($urandom_range(0, 9) != 0);
         START         = ($urandom_range(0, 15) != 0);
         ID_stall_i    = ($urandom_range(0, 3) == 0);
         IMEM_gnt_i    = ($urandom_range(0, 2) != 0);
         IMEM_rvalid_i = mem_pend && ($urandom_range(0, 2) != 0);
         IMEM_rdata_i  = $urandom();
         BR_redirect_i = ($urandom_range(0, 19) == 0);
         BR_target_i   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
         #1;
         if (IMEM_rvalid_i) mem_pend = 1'b0;
         if (IMEM_req_o && IMEM_gnt_i) mem_pend = 1'b1;
         tick();
      end
      quiet_inputs();
   endtask

   initial begin
      RSTn  = 1'b0;
      EN    = 1'b0;
      START = 1'b0;
      quiet_inputs();
      mem_pend = 1'b0;
      @(negedge CLK);
      test_reset();
      test_perf();
      test_first_fetch();
      test_stall_fill();
      test_redirect_wait();
      test_redirect_rvalid();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
